// File: rtl/seven_seg_scan_ctrl_if.sv
// Write-only 8-bit system bus seen by the seven-segment scan controller.
`timescale 1ns/1ps
interface seven_seg_scan_ctrl_if;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data;

  modport master (output we, addr, data);
  modport slave  (input  we, addr, data);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Bus-mapped N-digit multiplexed seven-segment controller with an anti-ghost blank slot.
// Optional build macro SEVEN_SEG_DIMMING_EN enables PWM brightness from CTRL[7:4].
`timescale 1ns/1ps
module seven_seg_scan_ctrl #(
  parameter logic [7:0] BASE_ADDR    = 8'hD0,
  parameter int         N_DIGITS     = 4,
  parameter int         REFRESH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  bus,
  output logic [N_DIGITS-1:0]   sel,
  output logic [7:0]            digit
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [REFRESH_LOG2-1:0] PRESC_LAST = '1;

  typedef enum logic [2:0] {
    ST_OFF   = 3'b001,
    ST_BLANK = 3'b010,
    ST_SHOW  = 3'b100
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [5:0]              digreg_r [N_DIGITS];
  logic [7:0]              ctrl_r;
  state_t                  state_r, state_nxt;
  logic [IDX_W-1:0]        idx_r, idx_nxt;
  logic [REFRESH_LOG2-1:0] presc_r, presc_nxt;
  logic [N_DIGITS-1:0]     sel_r, sel_nxt, lit_s;
  logic [7:0]              digit_r, digit_nxt;
  logic [7:0]              offset_s;
  logic                    wr_ctrl_s;
  logic [N_DIGITS-1:0]     wr_dig_s;
  logic [5:0]              cur_s;
  logic                    unused_ctrl_s;

  assign unused_ctrl_s = ^ctrl_r[7:1];

  // Bus address decode into per-register write strobes.
  always_comb begin
    offset_s  = bus.addr - BASE_ADDR;
    wr_ctrl_s = bus.we && (offset_s == 8'(N_DIGITS));
    wr_dig_s  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      wr_dig_s[i] = bus.we && (offset_s == 8'(i));
    end
  end

  // Digit and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= 8'hF1;
      for (int i = 0; i < N_DIGITS; i++) begin
        digreg_r[i] <= 6'h00;
      end
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r <= bus.data;
      end
      for (int i = 0; i < N_DIGITS; i++) begin
        if (wr_dig_s[i]) begin
          digreg_r[i] <= bus.data[5:0];
        end
      end
    end
  end

  // State, scan index, prescaler and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      idx_r   <= '0;
      presc_r <= '0;
      sel_r   <= '1;
      digit_r <= 8'hFF;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      presc_r <= presc_nxt;
      sel_r   <= sel_nxt;
      digit_r <= digit_nxt;
    end
  end

  // Next state plus slot counters; disable overrides every state.
  always_comb begin
    state_nxt = ST_BLANK;
    if (!ctrl_r[0]) begin
      state_nxt = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF:   state_nxt = ST_BLANK;
        ST_BLANK: state_nxt = ST_SHOW;
        ST_SHOW:  state_nxt = (presc_r == PRESC_LAST) ? ST_BLANK : ST_SHOW;
        default:  state_nxt = ST_BLANK;
      endcase
    end

    if ((state_r == ST_SHOW) && (state_nxt == ST_SHOW)) begin
      presc_nxt = presc_r + 1'b1;
    end else begin
      presc_nxt = '0;
    end

    if (state_nxt == ST_OFF) begin
      idx_nxt = '0;
    end else if ((state_r == ST_SHOW) && (state_nxt == ST_BLANK)) begin
      idx_nxt = (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
    end else begin
      idx_nxt = idx_r;
    end
  end

  // Pin values for the upcoming cycle; the digit register is read live for write-through.
  always_comb begin
    cur_s     = digreg_r[idx_nxt];
    lit_s     = ~(N_DIGITS'(1) << idx_nxt);
    sel_nxt   = '1;
    digit_nxt = 8'hFF;
    case (state_nxt)
      ST_SHOW: begin
`ifdef SEVEN_SEG_DIMMING_EN
        if (presc_nxt[REFRESH_LOG2-1 -: 4] <= ctrl_r[7:4]) begin
          sel_nxt = lit_s;
        end else begin
          sel_nxt = '1;
        end
`else
        sel_nxt = lit_s;
`endif
        digit_nxt = cur_s[5] ? 8'hFF : {~cur_s[4], hex_to_seg(cur_s[3:0])};
      end
      default: begin
        sel_nxt   = '1;
        digit_nxt = 8'hFF;
      end
    endcase
  end

  assign sel   = sel_r;
  assign digit = digit_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (N_DIGITS=4, REFRESH_LOG2=4, BASE_ADDR=D0).
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

`ifdef SEVEN_SEG_DIMMING_EN
  localparam int DIM_LOW = 4;
`else
  localparam int DIM_LOW = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sel;
  logic [7:0] digit;
  int         n_checks = 0;
  int         n_fail = 0;

  seven_seg_scan_ctrl_if bus();

  seven_seg_scan_ctrl #(
    .BASE_ADDR   (8'hD0),
    .N_DIGITS    (4),
    .REFRESH_LOG2(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .sel  (sel),
    .digit(digit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.data = d;
    @(posedge clk);
    #1 bus.we = 1'b0;
    @(negedge clk);
  endtask

  // Called at the first SHOW cycle of a slot; leaves the bench at the first cycle of the next slot.
  task automatic slot(input logic [3:0] es, input logic [7:0] ed, input int elow, input string tag);
    int low = 0;
    int stray = 0;
    check_eq({tag, "_digit"}, digit, ed);
    for (int i = 0; i < 16; i++) begin
      if (sel == es) low++;
      else if (sel != 4'hF) stray++;
      step();
    end
    check_eq({tag, "_low_cycles"}, low, elow);
    check_eq({tag, "_stray_sel"}, stray, 0);
    check_eq({tag, "_blank_sel"}, sel, 4'hF);
    step();
  endtask

  // Advance to the first cycle where sel becomes es right after an all-high cycle.
  task automatic sync_to(input logic [3:0] es, input string tag);
    logic [3:0] prev;
    int found = 0;
    prev = sel;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (prev == 4'hF && sel == es) found = 1;
      prev = sel;
    end
    check_eq({tag, "_sync"}, found, 1);
  endtask

  initial begin
    int not_off;
    bus.we   = 1'b0;
    bus.addr = 8'h00;
    bus.data = 8'h00;

    // Reset state and first slot after release
    repeat (3) step();
    check_eq("rst_sel", sel, 4'hF);
    check_eq("rst_digit", digit, 8'hFF);
    rst_n = 1'b1;
    #1 check_eq("first_blank_sel", sel, 4'hF);
    step();
    slot(4'hE, 8'hC0, DIM_LOW == 4 ? 16 : 16, "rst_slot0");
    check_eq("rst_slot1_sel", sel, 4'hD);

    // Asynchronous reset in the middle of a SHOW slot
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_sel", sel, 4'hF);
    check_eq("async_rst_digit", digit, 8'hFF);
    step();
    rst_n = 1'b1;
    #1 check_eq("rerelease_blank", sel, 4'hF);
    step();
    slot(4'hE, 8'hC0, 16, "rerelease_slot0");

    // Scan order and frame wrap
    write_reg(8'hD0, 8'h01);
    write_reg(8'hD1, 8'h02);
    write_reg(8'hD2, 8'h03);
    write_reg(8'hD3, 8'h04);
    sync_to(4'hE, "scan");
    slot(4'hE, 8'hF9, 16, "scan0");
    slot(4'hD, 8'hA4, 16, "scan1");
    slot(4'hB, 8'hB0, 16, "scan2");
    slot(4'h7, 8'h99, 16, "scan3");
    slot(4'hE, 8'hF9, 16, "scan_wrap");

    // Blank and dp attributes, out-of-range address
    write_reg(8'hD1, 8'h38);
    sync_to(4'hD, "blank");
    slot(4'hD, 8'hFF, 16, "blank_attr");
    write_reg(8'hD1, 8'h18);
    sync_to(4'hD, "dp");
    slot(4'hD, 8'h00, 16, "dp_attr");
    write_reg(8'hD5, 8'h00);
    sync_to(4'hE, "range");
    slot(4'hE, 8'hF9, 16, "range_slot0");
    check_eq("range_slot1_sel", sel, 4'hD);

    // Disable and re-enable
    write_reg(8'hD4, 8'h00);
    step();
    check_eq("off_sel", sel, 4'hF);
    check_eq("off_digit", digit, 8'hFF);
    not_off = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel != 4'hF || digit != 8'hFF) not_off++;
      step();
    end
    check_eq("off_held", not_off, 0);
    write_reg(8'hD4, 8'hF1);
    step();
    check_eq("reen_blank", sel, 4'hF);
    step();
    check_eq("reen_sel", sel, 4'hE);
    slot(4'hE, 8'hF9, 16, "reen_slot0");

    // Live update while digit 0 is shown
    sync_to(4'hE, "live");
    repeat (2) step();
    write_reg(8'hD0, 8'h0A);
    check_eq("live_write_edge", digit, 8'hF9);
    step();
    check_eq("live_next_cycle", digit, 8'h88);
    check_eq("live_sel", sel, 4'hE);

    // Brightness 3: quarter duty in the dimming build, full duty otherwise
    write_reg(8'hD4, 8'h31);
    sync_to(4'hE, "dim");
    slot(4'hE, 8'h88, DIM_LOW, "dim_slot0");
    slot(4'hD, 8'h00, DIM_LOW, "dim_slot1");
    write_reg(8'hD4, 8'hF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
